// File: rtl/instr_loader.sv
// instr_loader: receives a program as a little-endian byte stream, writes it
// word by word into instruction memory, then verifies a trailing XOR checksum
// byte before releasing the core from reset.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, word_count_i   load request and its word count (sampled on start)
//   byte_valid_i, byte_i    byte source handshake (accepted when ready & valid)
//   byte_ready_o            loader can take a byte this cycle
//   IWR_EN_o, address_o,
//   DATA_o                  instruction-memory write port
//   core_rst_o              holds the core in reset until a good load completes
//   busy_o, done_o, err_o   load status
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] word_count_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        IWR_EN_o,
    output logic [31:0] address_o,
    output logic [31:0] DATA_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_W  = 17'(MAX_WORDS);
    localparam logic [31:0] STEP_W = 32'(ADDR_STEP);

    state_t      state;
    state_t      state_nxt;
    state_t      launch_state;
    logic [1:0]  byte_idx;
    logic [15:0] remaining;
    logic [7:0]  xor_sum;
    logic        accept;

    assign accept = byte_valid_i && byte_ready_o;

    // Destination of a start request from any of the idle-like states.
    assign launch_state = (word_count_i == '0)            ? DONE  :
                          ({1'b0, word_count_i} > MAX_W)  ? ERROR :
                                                            RECV;

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        IWR_EN_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        core_rst_o   = 1'b1;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = launch_state;
            end
            RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                IWR_EN_o  = 1'b1;
                busy_o    = 1'b1;
                state_nxt = (remaining == 16'd1) ? CHECK : RECV;
            end
            CHECK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept) state_nxt = (byte_i == xor_sum) ? DONE : ERROR;
            end
            DONE: begin
                done_o     = 1'b1;
                core_rst_o = 1'b0;
                if (start_i) state_nxt = launch_state;
            end
            ERROR: begin
                err_o = 1'b1;
                if (start_i) state_nxt = launch_state;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            byte_idx  <= '0;
            remaining <= '0;
            xor_sum   <= '0;
            address_o <= BASE_ADDR;
            DATA_o    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_i && launch_state == RECV) begin
                        remaining <= word_count_i;
                        byte_idx  <= '0;
                        xor_sum   <= '0;
                        address_o <= BASE_ADDR;
                    end
                end
                RECV: begin
                    if (accept) begin
                        DATA_o[{byte_idx, 3'b000} +: 8] <= byte_i;
                        xor_sum  <= xor_sum ^ byte_i;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    address_o <= address_o + STEP_W;
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader. A second instance with a base address at
// the top of the 32-bit space shares all inputs to exercise address wrap.
module tb_instr_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] word_count_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;

    logic        byte_ready_o, IWR_EN_o, core_rst_o, busy_o, done_o, err_o;
    logic [31:0] address_o, DATA_o;
    logic        byte_ready_w, IWR_EN_w, core_rst_w, busy_w, done_w, err_w;
    logic [31:0] address_w, DATA_w;

    int checks   = 0;
    int failures = 0;

    logic [63:0] wq[$];
    logic [63:0] wq2[$];
    logic [31:0] words[8];
    int          nwr;

    instr_loader dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .word_count_i(word_count_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .byte_ready_o(byte_ready_o), .IWR_EN_o(IWR_EN_o),
        .address_o(address_o), .DATA_o(DATA_o), .core_rst_o(core_rst_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    instr_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .word_count_i(word_count_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .byte_ready_o(byte_ready_w), .IWR_EN_o(IWR_EN_w),
        .address_o(address_w), .DATA_o(DATA_w), .core_rst_o(core_rst_w),
        .busy_o(busy_w), .done_o(done_w), .err_o(err_w)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: one entry per cycle that IWR_EN is high.
    always @(negedge clk_i) begin
        if (IWR_EN_o) begin
            wq.push_back({address_o, DATA_o});
            check("write_ready_low", {63'd0, byte_ready_o}, 64'd0);
        end
        if (IWR_EN_w) wq2.push_back({address_w, DATA_w});
        if (done_o || err_o) check("done_err_exclusive", {63'd0, done_o & err_o}, 64'd0);
    end

    function automatic logic [7:0] xsum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        return s;
    endfunction

    // Inputs change on the falling edge; a byte is taken at the rising edge
    // that follows a falling edge where ready was seen high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk_i);
            byte_valid_i = 1'b0;
            byte_i       = 8'($urandom);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_i       = b;
        while (!byte_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!byte_ready_o) check("byte_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic load(input int n, input logic [7:0] chk, input int maxgap);
        @(negedge clk_i);
        start_i      = 1'b1;
        word_count_i = 16'(n);
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", {63'd0, busy_o}, 64'd1);
        check("core_rst_loading", {63'd0, core_rst_o}, 64'd1);
        check("err_clear_on_start", {63'd0, err_o}, 64'd0);
        check("done_clear_on_start", {63'd0, done_o}, 64'd0);
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++)
                send_byte(words[w][8*k +: 8], $urandom_range(0, maxgap));
        send_byte(chk, $urandom_range(0, maxgap));
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic check_writes(input int n, input logic [31:0] base);
        check("write_count", 64'(wq.size()), 64'(n));
        for (int i = 0; i < n; i++)
            check("write_addr_data", wq[i], {base + 32'(4 * i), words[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        word_count_i = '0;
        byte_valid_i = 1'b0;
        byte_i       = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {63'd0, byte_ready_o}, 64'd0);
        check("rst_iwr", {63'd0, IWR_EN_o}, 64'd0);
        check("rst_addr", 64'(address_o), 64'h0);
        check("rst_addr_wrapinst", 64'(address_w), 64'hFFFF_FFFC);
        check("rst_data", 64'(DATA_o), 64'h0);
        check("rst_core_rst", {63'd0, core_rst_o}, 64'd1);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        rst_i = 1'b0;

        // Two-word program; XOR of 13,00,50,00,B3,00,A0,00 is 0x50.
        words[0] = 32'h0050_0013;
        words[1] = 32'h00A0_00B3;
        wq.delete(); wq2.delete();
        load(2, 8'h50, 0);
        check("good_done", {63'd0, done_o}, 64'd1);
        check("good_core_rst", {63'd0, core_rst_o}, 64'd0);
        check("good_err", {63'd0, err_o}, 64'd0);
        check("good_busy", {63'd0, busy_o}, 64'd0);
        check_writes(2, 32'h0);
        check("wrap_count", 64'(wq2.size()), 64'd2);
        check("wrap_word0", wq2[0], {32'hFFFF_FFFC, 32'h0050_0013});
        check("wrap_word1", wq2[1], {32'h0000_0000, 32'h00A0_00B3});

        // Bad checksum, then retry from ERROR.
        wq.delete();
        load(2, 8'h50 ^ 8'h01, 1);
        check("bad_err", {63'd0, err_o}, 64'd1);
        check("bad_core_rst", {63'd0, core_rst_o}, 64'd1);
        check("bad_done", {63'd0, done_o}, 64'd0);
        check_writes(2, 32'h0);
        wq.delete();
        load(2, xsum(2), 1);
        check("retry_done", {63'd0, done_o}, 64'd1);
        check("retry_err", {63'd0, err_o}, 64'd0);
        check_writes(2, 32'h0);

        // Count above MAX_WORDS, then zero count from ERROR.
        wq.delete();
        @(negedge clk_i); start_i = 1'b1; word_count_i = 16'd1025;
        @(negedge clk_i); start_i = 1'b0;
        check("over_err", {63'd0, err_o}, 64'd1);
        check("over_busy", {63'd0, busy_o}, 64'd0);
        check("over_core_rst", {63'd0, core_rst_o}, 64'd1);
        start_i = 1'b1; word_count_i = 16'd0;
        @(negedge clk_i); start_i = 1'b0;
        check("zero_done", {63'd0, done_o}, 64'd1);
        check("zero_err", {63'd0, err_o}, 64'd0);
        check("zero_core_rst", {63'd0, core_rst_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        check("zero_no_write", 64'(wq.size()), 64'd0);

        // Start ignored while busy; MAX_WORDS itself is a legal count.
        @(negedge clk_i); start_i = 1'b1; word_count_i = 16'd1024;
        @(negedge clk_i);
        check("max_busy", {63'd0, busy_o}, 64'd1);
        word_count_i = 16'd0;
        @(negedge clk_i); start_i = 1'b0;
        check("start_ignored_busy", {63'd0, busy_o}, 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;

        // Random data with gappy byte_valid, valid held through WRITE.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        wq.delete();
        load(4, xsum(4), 3);
        check("rand_done", {63'd0, done_o}, 64'd1);
        check_writes(4, 32'h0);

        // Reset in the middle of word 1.
        words[0] = 32'h1122_3344;
        words[1] = 32'h5566_7788;
        wq.delete();
        @(negedge clk_i); start_i = 1'b1; word_count_i = 16'd2;
        @(negedge clk_i); start_i = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 0);
        for (int k = 0; k < 2; k++) send_byte(words[1][8*k +: 8], 0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        nwr = wq.size();
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_ready", {63'd0, byte_ready_o}, 64'd0);
        check("mid_rst_iwr", {63'd0, IWR_EN_o}, 64'd0);
        check("mid_rst_addr", 64'(address_o), 64'h0);
        check("mid_rst_data", 64'(DATA_o), 64'h0);
        check("mid_rst_core_rst", {63'd0, core_rst_o}, 64'd1);
        check("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        check("mid_rst_done_err", {62'd0, done_o, err_o}, 64'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("mid_rst_writes_before", 64'(nwr), 64'd1);
        check("mid_rst_no_more_writes", 64'(wq.size()), 64'd1);
        wq.delete();
        load(2, xsum(2), 2);
        check("after_rst_done", {63'd0, done_o}, 64'd1);
        check_writes(2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
